// File: rtl/spi_dds_cmd_ctrl.sv
// Command sequencer between the SPI frame receiver and the DDS core: decodes
// 40-bit frames, stages config in shadow registers and commits them atomically.
module spi_dds_cmd_ctrl #(
   parameter int unsigned FRAME_W = 40,
   parameter int unsigned FTW_W   = 32,
   parameter int unsigned POW_W   = 16,
   parameter int unsigned ERR_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               frame_valid_i,
   input  logic [FRAME_W-1:0] frame_i,
   input  logic               cs_active_i,
   output logic [FRAME_W-1:0] resp_o,
   output logic               resp_load_o,
   output logic [FTW_W-1:0]   ftw_o,
   output logic [POW_W-1:0]   pow_o,
   output logic [1:0]         wave_sel_o,
   output logic               dds_en_o,
   output logic               dds_update_o,
   output logic               phase_rst_o,
   output logic               busy_o,
   output logic [ERR_W-1:0]   err_cnt_o
);

   localparam int unsigned OP_W  = 8;
   localparam int unsigned PAY_W = FRAME_W - OP_W;

   localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
   localparam logic [OP_W-1:0] OP_FTW    = 8'h01;
   localparam logic [OP_W-1:0] OP_POW    = 8'h02;
   localparam logic [OP_W-1:0] OP_CFG    = 8'h03;
   localparam logic [OP_W-1:0] OP_COMMIT = 8'h10;
   localparam logic [OP_W-1:0] OP_PRST   = 8'h11;
   localparam logic [OP_W-1:0] OP_RD_FTW = 8'h20;
   localparam logic [OP_W-1:0] OP_RD_ST  = 8'h21;
   localparam logic [OP_W-1:0] OP_ILL    = 8'hEE;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT_CS, S_RESP} state_t;
   typedef enum logic [3:0] {
      K_NOP, K_FTW, K_POW, K_CFG, K_COMMIT, K_PRST, K_RD_FTW, K_RD_ST, K_ILLEGAL
   } kind_t;

   state_t             state;
   kind_t              kind;
   kind_t              kind_c;
   logic [OP_W-1:0]    op_q;
   logic [PAY_W-1:0]   pay_q;
   logic [FTW_W-1:0]   shadow_ftw;
   logic [POW_W-1:0]   shadow_pow;
   logic [1:0]         shadow_wave;
   logic               shadow_en;
   logic               commit_pending;
   logic               commit_now_c;
   logic [1:0]         err_inc_c;
   logic [ERR_W+1:0]   err_sum_c;
   logic [ERR_W-1:0]   err_next_c;
   logic [FRAME_W-1:0] resp_c;

   // Opcode classification of the latched frame
   always_comb begin
      kind_c = K_ILLEGAL;
      unique case (op_q)
         OP_NOP:    kind_c = K_NOP;
         OP_FTW:    kind_c = K_FTW;
         OP_POW:    kind_c = K_POW;
         OP_CFG:    kind_c = K_CFG;
         OP_COMMIT: kind_c = K_COMMIT;
         OP_PRST:   kind_c = K_PRST;
         OP_RD_FTW: kind_c = K_RD_FTW;
         OP_RD_ST:  kind_c = K_RD_ST;
         default:   kind_c = K_ILLEGAL;
      endcase
   end

   // Saturating error accounting: overrun and illegal opcode may coincide (+2)
   always_comb begin
      err_inc_c  = 2'(frame_valid_i && busy_o) + 2'(state == S_EXEC && kind == K_ILLEGAL);
      err_sum_c  = (ERR_W+2)'(err_cnt_o) + (ERR_W+2)'(err_inc_c);
      err_next_c = (err_sum_c > (ERR_W+2)'(ERR_MAX)) ? ERR_MAX : err_sum_c[ERR_W-1:0];
   end

   // Commit fires on the first sampled cycle without an SPI transaction in flight
   always_comb begin
      commit_now_c = !cs_active_i &&
                     ((state == S_EXEC && kind == K_COMMIT) ||
                      (state == S_WAIT_CS && commit_pending));
   end

   always_comb begin
      resp_c = {op_q, pay_q};
      unique case (kind)
         K_RD_FTW:  resp_c = FRAME_W'({OP_RD_FTW, ftw_o});
         K_RD_ST:   resp_c = FRAME_W'({OP_RD_ST, 12'h000, commit_pending, dds_en_o,
                                       wave_sel_o, err_cnt_o, 8'hA5});
         K_ILLEGAL: resp_c = FRAME_W'({OP_ILL, 24'h000000, op_q});
         default:   resp_c = {op_q, pay_q};
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= S_IDLE;
         kind           <= K_NOP;
         op_q           <= '0;
         pay_q          <= '0;
         shadow_ftw     <= '0;
         shadow_pow     <= '0;
         shadow_wave    <= '0;
         shadow_en      <= 1'b0;
         commit_pending <= 1'b0;
         resp_o         <= '0;
         resp_load_o    <= 1'b0;
         ftw_o          <= '0;
         pow_o          <= '0;
         wave_sel_o     <= '0;
         dds_en_o       <= 1'b0;
         dds_update_o   <= 1'b0;
         phase_rst_o    <= 1'b0;
         busy_o         <= 1'b0;
         err_cnt_o      <= '0;
      end else begin
         dds_update_o <= 1'b0;
         phase_rst_o  <= 1'b0;
         resp_load_o  <= 1'b0;
         err_cnt_o    <= err_next_c;

         unique case (state)
            S_IDLE: begin
               if (frame_valid_i) begin
                  op_q   <= frame_i[FRAME_W-1:PAY_W];
                  pay_q  <= frame_i[PAY_W-1:0];
                  busy_o <= 1'b1;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               kind  <= kind_c;
               state <= S_EXEC;
            end
            S_EXEC: begin
               unique case (kind)
                  K_FTW:   shadow_ftw <= pay_q[FTW_W-1:0];
                  K_POW:   shadow_pow <= pay_q[POW_W-1:0];
                  K_CFG: begin
                     shadow_wave <= pay_q[1:0];
                     shadow_en   <= pay_q[8];
                  end
                  K_PRST:  phase_rst_o <= 1'b1;
                  default: ;
               endcase
               if (kind == K_COMMIT) begin
                  commit_pending <= cs_active_i;
                  state          <= S_WAIT_CS;
               end else begin
                  resp_o      <= resp_c;
                  resp_load_o <= 1'b1;
                  state       <= S_RESP;
               end
            end
            S_WAIT_CS: begin
               if (commit_pending) begin
                  if (!cs_active_i) commit_pending <= 1'b0;
               end else begin
                  resp_o      <= resp_c;
                  resp_load_o <= 1'b1;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (commit_now_c) begin
            ftw_o        <= shadow_ftw;
            pow_o        <= shadow_pow;
            wave_sel_o   <= shadow_wave;
            dds_en_o     <= shadow_en;
            dds_update_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_dds_cmd_ctrl.sv
// Scoreboard bench for spi_dds_cmd_ctrl: randomized and directed frames checked
// against a register-level model of the command protocol.
module tb_spi_dds_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fv  = 1'b0;
   logic        cs  = 1'b0;
   logic [39:0] frame = '0;
   logic [39:0] resp_o;
   logic        resp_load_o;
   logic [31:0] ftw_o;
   logic [15:0] pow_o;
   logic [1:0]  wave_sel_o;
   logic        dds_en_o, dds_update_o, phase_rst_o, busy_o;
   logic [7:0]  err_cnt_o;

   spi_dds_cmd_ctrl dut (
      .clk_i(clk), .rst_i(rst), .frame_valid_i(fv), .frame_i(frame),
      .cs_active_i(cs), .resp_o(resp_o), .resp_load_o(resp_load_o),
      .ftw_o(ftw_o), .pow_o(pow_o), .wave_sel_o(wave_sel_o), .dds_en_o(dds_en_o),
      .dds_update_o(dds_update_o), .phase_rst_o(phase_rst_o), .busy_o(busy_o),
      .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [39:0] resp; logic prst; int issue; int lat; } rsp_exp_t;
   typedef struct { logic [31:0] ftw; logic [15:0] pow; logic [1:0] wave; logic en;
                    int issue; int lat; } cmt_exp_t;
   rsp_exp_t rsp_q[$];
   cmt_exp_t cmt_q[$];
   rsp_exp_t re;
   cmt_exp_t ce;

   // Reference model: shadow and active configuration plus error count
   logic [31:0] s_ftw, m_ftw;
   logic [15:0] s_pow, m_pow;
   logic [1:0]  s_wave, m_wave;
   logic        s_en, m_en;
   int          m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=none (cycle %0d)", name, act, cyc);
   endtask

   function automatic logic legal(input logic [7:0] op);
      return op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21};
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic logic [7:0] rand_illegal();
      logic [7:0] o;
      do o = 8'($urandom); while (legal(o));
      return o;
   endfunction

   task automatic model_reset();
      s_ftw = '0; s_pow = '0; s_wave = '0; s_en = 1'b0;
      m_ftw = '0; m_pow = '0; m_wave = '0; m_en = 1'b0;
      m_err = 0;
   endtask

   // Issue one frame; hold = cycles cs stays high from issue; ovr = offset of a dropped extra frame
   task automatic send(input logic [7:0] op, input logic [31:0] pay, input int hold, input int ovr);
      logic [39:0] r;
      int          c0, lat;
      bit          done;
      @(negedge clk);
      c0 = cyc;
      if (ovr > 0) m_err = sat(m_err + 1);
      if (!legal(op))        r = {8'hEE, 24'h0, op};
      else if (op == 8'h20)  r = {8'h20, m_ftw};
      else if (op == 8'h21)  r = {8'h21, 12'h0, 1'b0, m_en, m_wave, 8'(m_err), 8'hA5};
      else                   r = {op, pay};
      lat = 3;
      case (op)
         8'h01: s_ftw = pay;
         8'h02: s_pow = pay[15:0];
         8'h03: begin s_wave = pay[1:0]; s_en = pay[8]; end
         8'h10: begin
            m_ftw = s_ftw; m_pow = s_pow; m_wave = s_wave; m_en = s_en;
            lat = (hold + 1 > 3) ? hold + 1 : 3;
            cmt_q.push_back('{m_ftw, m_pow, m_wave, m_en, c0, lat});
            lat = lat + 1;
         end
         default: ;
      endcase
      if (!legal(op)) m_err = sat(m_err + 1);
      rsp_q.push_back('{r, (op == 8'h11), c0, lat});

      fv = 1'b1; frame = {op, pay}; cs = (hold > 0);
      done = 1'b0;
      for (int k = 1; k < 40 + hold && !done; k++) begin
         @(negedge clk);
         fv = (k == ovr);
         if (k == ovr) frame = {8'h01, 32'hDEADBEEF};
         if (k >= hold) cs = 1'b0;
         if (!busy_o && !fv) done = 1'b1;
      end
      fv = 1'b0;
      if (!done) flag("busy_timeout", 64'(busy_o));
      chk("err_cnt", 64'(err_cnt_o), 64'(m_err));
      chk("scoreboard_drained", 64'(rsp_q.size() + cmt_q.size()), 64'd0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a response or a commit
   logic        mon_en = 1'b0;
   logic [50:0] prev_act;
   always @(negedge clk) begin
      if (mon_en) begin
         if (resp_load_o) begin
            if (rsp_q.size() == 0) flag("unexpected_resp_load", 64'(resp_o));
            else begin
               re = rsp_q.pop_front();
               chk("resp_word", 64'(resp_o), 64'(re.resp));
               chk("resp_latency", 64'(cyc - re.issue), 64'(re.lat));
               chk("phase_rst", 64'(phase_rst_o), 64'(re.prst));
            end
         end else if (phase_rst_o) flag("stray_phase_rst", 64'(phase_rst_o));
         if (dds_update_o) begin
            if (cmt_q.size() == 0) flag("unexpected_dds_update", 64'(ftw_o));
            else begin
               ce = cmt_q.pop_front();
               chk("commit_ftw", 64'(ftw_o), 64'(ce.ftw));
               chk("commit_pow", 64'(pow_o), 64'(ce.pow));
               chk("commit_wave_en", 64'({wave_sel_o, dds_en_o}), 64'({ce.wave, ce.en}));
               chk("commit_latency", 64'(cyc - ce.issue), 64'(ce.lat));
               chk("update_with_phase_rst", 64'(phase_rst_o), 64'd0);
            end
         end else if (!rst && {ftw_o, pow_o, wave_sel_o, dds_en_o} !== prev_act)
            flag("active_change_without_update", 64'(ftw_o));
         prev_act = {ftw_o, pow_o, wave_sel_o, dds_en_o};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] op;
      int         r;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_resp", 64'(resp_o), 64'd0);
      chk("rst_resp_load", 64'(resp_load_o), 64'd0);
      chk("rst_ftw", 64'(ftw_o), 64'd0);
      chk("rst_pow", 64'(pow_o), 64'd0);
      chk("rst_wave_en", 64'({wave_sel_o, dds_en_o}), 64'd0);
      chk("rst_pulses", 64'({dds_update_o, phase_rst_o}), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_err", 64'(err_cnt_o), 64'd0);
      rst = 1'b0;
      prev_act = {ftw_o, pow_o, wave_sel_o, dds_en_o};
      mon_en = 1'b1;

      // FTW write then immediate commit
      send(8'h01, 32'h12345678, 0, 0);
      send(8'h10, 32'h0, 0, 0);
      chk("t1_ftw", 64'(ftw_o), 64'h12345678);
      // Commit held off by a long SPI transaction
      send(8'h02, 32'h0000ABCD, 0, 0);
      send(8'h03, 32'h00000102, 0, 0);
      send(8'h10, 32'h0, 20, 0);
      chk("t2_pow", 64'(pow_o), 64'hABCD);
      chk("t2_wave_en", 64'({wave_sel_o, dds_en_o}), 64'b101);
      // Status and FTW readback
      send(8'h21, 32'h0, 0, 0);
      send(8'h20, 32'h0, 0, 0);
      // Illegal opcode, overruns, and the combined +2 case
      send(8'h7F, 32'h0, 0, 0);
      send(8'h00, 32'h0, 0, 1);
      send(8'h55, 32'h0, 0, 2);
      send(8'h00, 32'h0, 0, 3);
      send(8'h10, 32'h0, 0, 0);
      chk("dropped_frame_not_written", 64'(ftw_o), 64'h12345678);
      send(8'h11, 32'h0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0: op = 8'h00;  1: op = 8'h01;  2: op = 8'h02;  3: op = 8'h03;
            4: op = 8'h10;  5: op = 8'h11;  6: op = 8'h20;  7: op = 8'h21;
            default: op = rand_illegal();
         endcase
         send(op, $urandom, (op == 8'h10) ? int'($urandom_range(0, 8)) : 0,
              ($urandom_range(0, 5) == 0) ? 1 : 0);
      end

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) send(rand_illegal(), $urandom, 0, 0);
      chk("err_saturated", 64'(err_cnt_o), 64'd255);
      send(8'h21, 32'h0, 0, 0);

      // Reset while a commit is parked in WAIT_CS
      send(8'h01, 32'h0BADF00D, 0, 0);
      @(negedge clk);
      fv = 1'b1; frame = {8'h10, 32'h0}; cs = 1'b1;
      @(negedge clk);
      fv = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("wrst_ftw", 64'(ftw_o), 64'd0);
      chk("wrst_pow_wave_en", 64'({pow_o, wave_sel_o, dds_en_o}), 64'd0);
      chk("wrst_busy_err", 64'({busy_o, err_cnt_o}), 64'd0);
      chk("wrst_resp", 64'(resp_o), 64'd0);
      repeat (4) @(negedge clk);
      chk("wrst_no_update", 64'(ftw_o), 64'd0);
      send(8'h21, 32'h0, 0, 0);
      send(8'h01, 32'hCAFEF00D, 0, 0);
      send(8'h10, 32'h0, 0, 0);
      chk("post_rst_ftw", 64'(ftw_o), 64'hCAFEF00D);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
